// File: rtl/ods_stream.sv
// Word-to-column packer: gathers NUM_ROWS words into a column and buffers up to
// DEPTH complete columns in a FIFO. Flush closes a partial column, zero-filling the unwritten rows.
module ods_stream #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NUM_ROWS      = 3,
  parameter int DEPTH         = 2,
  localparam int RP_W         = $clog2(NUM_ROWS),
  localparam int CNT_W        = $clog2(DEPTH + 1),
  localparam int COL_W        = NUM_ROWS * IO_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     arst_in,
  input  logic [IO_DATA_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [COL_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RP_W-1:0]          row_ptr,
  output logic [CNT_W-1:0]         col_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IO_DATA_WIDTH-1:0] r_stage [NUM_ROWS-1];
  logic [COL_W-1:0]         r_mem   [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [RP_W-1:0]          r_row_ptr;
  logic [CNT_W-1:0]         r_count;

  logic             w_last;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_accept;
  logic             w_flush_push;
  logic             w_push;
  logic [COL_W-1:0] w_col;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_last       = (r_row_ptr == RP_W'(NUM_ROWS - 1));
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_pop        = out_valid && out_ready;
  assign w_push_ok    = !w_full || w_pop;
  // Only the word that completes a column can be blocked by a full buffer.
  assign in_ready     = !flush && !(w_last && w_full && !out_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_flush_push = flush && (r_row_ptr != '0) && w_push_ok;
  assign w_push       = (w_accept && w_last) || w_flush_push;

  // On flush, rows at or beyond row_ptr hold stale words and must read as zero.
  always_comb begin
    w_col = '0;
    for (int i = 0; i < NUM_ROWS - 1; i++) begin
      if (!w_flush_push || (RP_W'(i) < r_row_ptr))
        w_col[i*IO_DATA_WIDTH +: IO_DATA_WIDTH] = r_stage[i];
    end
    if (!w_flush_push)
      w_col[(NUM_ROWS-1)*IO_DATA_WIDTH +: IO_DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_row_ptr <= '0;
      for (int i = 0; i < NUM_ROWS - 1; i++) r_stage[i] <= '0;
    end else if (w_push) begin
      r_row_ptr <= '0;
    end else if (w_accept) begin
      r_row_ptr <= r_row_ptr + 1'b1;
      for (int i = 0; i < NUM_ROWS - 1; i++) begin
        if (r_row_ptr == RP_W'(i)) r_stage[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_col;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign row_ptr   = r_row_ptr;
  assign col_count = r_count;

endmodule

// File: tb/tb_ods_stream.sv
// Directed and randomized checks of ods_stream with 3 rows, depth 2, 16-bit words.
module tb_ods_stream;

  logic        clk;
  logic        arst_in;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  row_ptr;
  logic [1:0]  col_count;

  int n_total = 0;
  int n_fail  = 0;

  ods_stream #(.IO_DATA_WIDTH(16), .NUM_ROWS(3), .DEPTH(2)) dut (
    .clk       (clk),
    .arst_in   (arst_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .row_ptr   (row_ptr),
    .col_count (col_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] mst [2];
  int          mrow;
  logic [47:0] q [$];
  logic [47:0] col;
  logic        exp_rdy;
  logic        pop;

  initial begin
    arst_in   = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    mrow      = 0;
    #1;
    check("rst_row_ptr",   48'(row_ptr),   48'd0);
    check("rst_col_count", 48'(col_count), 48'd0);
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_out_data",  out_data,       48'd0);
    check("rst_in_ready",  48'(in_ready),  48'd1);
    flush = 1'b1;
    #1;
    check("rst_in_ready_flush", 48'(in_ready), 48'd0);
    flush = 1'b0;
    tick();
    tick();
    arst_in = 1'b0;

    // First column, 1-cycle latency
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    check("col1_valid", 48'(out_valid), 48'd1);
    check("col1_data",  out_data,       48'h0003_0002_0001);
    check("col1_count", 48'(col_count), 48'd1);
    check("col1_row",   48'(row_ptr),   48'd0);

    // Fill buffer, then partial column while full
    send(16'h0004);
    send(16'h0005);
    send(16'h0006);
    check("full_count", 48'(col_count), 48'd2);
    check("full_hold",  out_data,       48'h0003_0002_0001);
    send(16'h0007);
    check("w7_row", 48'(row_ptr), 48'd1);
    in_data = 16'h0008; in_valid = 1'b1;
    #1;
    check("w8_ready", 48'(in_ready), 48'd1);
    tick();
    check("w8_row", 48'(row_ptr), 48'd2);
    in_data = 16'h0009;
    #1;
    check("w9_blocked", 48'(in_ready), 48'd0);
    tick();
    check("w9_row_hold",   48'(row_ptr),   48'd2);
    check("w9_count_hold", 48'(col_count), 48'd2);
    out_ready = 1'b1;
    #1;
    check("w9_ready_pop", 48'(in_ready), 48'd1);
    check("pop0_data",    out_data,      48'h0003_0002_0001);
    tick();
    in_valid = 1'b0;
    check("w9_count", 48'(col_count), 48'd2);
    check("w9_row",   48'(row_ptr),   48'd0);
    check("pop1_data", out_data,      48'h0006_0005_0004);
    tick();
    check("pop2_count", 48'(col_count), 48'd1);
    check("pop2_data",  out_data,       48'h0009_0008_0007);
    tick();
    check("drain_valid", 48'(out_valid), 48'd0);
    out_ready = 1'b0;

    // Flush of a partial column; in_valid ignored during flush
    send(16'h00AA);
    check("aa_row",      48'(row_ptr),   48'd1);
    check("aa_hidden",   48'(out_valid), 48'd0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h00BB;
    #1;
    check("flush_ready", 48'(in_ready), 48'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_data",  out_data,       48'h0000_0000_00AA);
    check("flush_row",   48'(row_ptr),   48'd0);
    check("flush_count", 48'(col_count), 48'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush0_count", 48'(col_count), 48'd1);
    check("flush0_row",   48'(row_ptr),   48'd0);

    // Flush blocked by a full buffer retries until a pop frees space
    send(16'h00D1);
    send(16'h00D2);
    send(16'h00D3);
    send(16'h00E1);
    flush = 1'b1;
    tick();
    check("fretry_row",   48'(row_ptr),   48'd1);
    check("fretry_count", 48'(col_count), 48'd2);
    check("fretry_data",  out_data,       48'h0000_0000_00AA);
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("fpush_count", 48'(col_count), 48'd2);
    check("fpush_row",   48'(row_ptr),   48'd0);
    check("fpush_data",  out_data,       48'h00D3_00D2_00D1);
    tick();
    check("fmask_data",  out_data,       48'h0000_0000_00E1);
    tick();
    check("fdrain_valid", 48'(out_valid), 48'd0);
    out_ready = 1'b0;

    // Reset mid-column discards staged words
    send(16'h0011);
    send(16'h0022);
    arst_in = 1'b1;
    #1;
    check("mrst_row",  48'(row_ptr),   48'd0);
    check("mrst_data", out_data,       48'd0);
    check("mrst_cnt",  48'(col_count), 48'd0);
    tick();
    arst_in = 1'b0;
    send(16'h0033);
    send(16'h0044);
    send(16'h0055);
    check("mrst_col",   out_data,       48'h0055_0044_0033);
    check("mrst_count", 48'(col_count), 48'd1);
    out_ready = 1'b1;
    tick();
    check("mrst_empty", 48'(out_valid), 48'd0);
    out_ready = 1'b0;

    // Randomized traffic against a reference FIFO model
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = 16'($urandom);
      #1;
      exp_rdy = !flush && !(mrow == 2 && q.size() == 2 && !out_ready);
      check("rnd_in_ready",  48'(in_ready),  48'(exp_rdy));
      check("rnd_out_valid", 48'(out_valid), 48'(q.size() != 0));
      check("rnd_col_count", 48'(col_count), 48'(q.size()));
      check("rnd_row_ptr",   48'(row_ptr),   48'(mrow));
      if (q.size() != 0) check("rnd_out_data", out_data, q[0]);
      pop = (q.size() != 0) && out_ready;
      if (!flush && in_valid && exp_rdy) begin
        if (mrow == 2) begin
          col = {in_data, mst[1], mst[0]};
          if (pop) void'(q.pop_front());
          q.push_back(col);
          mrow = 0;
        end else begin
          mst[mrow] = in_data;
          mrow++;
          if (pop) void'(q.pop_front());
        end
      end else if (flush && mrow != 0 && (q.size() < 2 || pop)) begin
        col = '0;
        for (int i = 0; i < mrow; i++) col[i*16 +: 16] = mst[i];
        if (pop) void'(q.pop_front());
        q.push_back(col);
        mrow = 0;
      end else if (pop) begin
        void'(q.pop_front());
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
